// File: rtl/semaforo_pkg.sv
// rtl/semaforo_pkg.sv - pedestrian state encodings and light one-hot constants
package semaforo_pkg;

    typedef enum logic [1:0] {
        ST_DW    = 2'd0,
        ST_WALK  = 2'd1,
        ST_FLASH = 2'd2,
        ST_FAULT = 2'd3
    } ped_state_t;

    // {green, yellow, red}
    localparam logic [2:0] LIGHT_GO   = 3'b100;
    localparam logic [2:0] LIGHT_WAIT = 3'b010;
    localparam logic [2:0] LIGHT_STOP = 3'b001;

    function automatic logic is_onehot(input logic [2:0] lights);
        return (lights == LIGHT_GO) || (lights == LIGHT_WAIT) || (lights == LIGHT_STOP);
    endfunction

endpackage

// File: rtl/ped_req_sync.sv
// rtl/ped_req_sync.sv - 2-FF synchroniser plus rising-edge pulse for the push-button
module ped_req_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_async,
    output logic pulse
);

    logic r_meta;
    logic r_sync;
    logic r_sync_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_sync_d <= 1'b0;
        end else begin
            r_meta   <= d_async;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
        end
    end

    assign pulse = r_sync & ~r_sync_d;

endmodule

// File: rtl/cruce_peatonal.sv
// rtl/cruce_peatonal.sv - pedestrian WALK/DON'T WALK stage driven by the traffic-light FSM
module cruce_peatonal
    import semaforo_pkg::*;
#(
    parameter int WALK_TICKS  = 2,
    parameter int FLASH_TICKS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       green,
    input  logic       yellow,
    input  logic       red,
    input  logic       ped_req,
    output logic       walk,
    output logic       dont_walk,
    output logic       req_pend,
    output logic [3:0] countdown,
    output logic       fault
);

    localparam logic [3:0] WALK_CNT  = 4'(WALK_TICKS);
    localparam logic [3:0] FLASH_CNT = 4'(FLASH_TICKS);

    ped_state_t r_state, w_state_nx;
    logic [3:0] r_cnt, w_cnt_nx;
    logic       r_blink, w_blink_nx;
    logic       r_req_pend, w_req_pend_nx;
    logic       r_red_d;
    logic       r_bad_d;
    logic       r_walk, r_dont_walk, r_fault;
    logic [3:0] r_countdown;

    logic       w_req_pulse;
    logic       w_red_rise;
    logic       w_bad;

    ped_req_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .d_async (ped_req),
        .pulse   (w_req_pulse)
    );

    assign w_red_rise = red & ~r_red_d;
    assign w_bad      = ~is_onehot({green, yellow, red});

    always_comb begin
        w_state_nx    = r_state;
        w_cnt_nx      = r_cnt;
        w_blink_nx    = r_blink;
        w_req_pend_nx = r_req_pend;
        // Two consecutive bad clks filter out a one-clk glitch during light changes
        if (w_bad && r_bad_d) begin
            w_state_nx = ST_FAULT;
            w_cnt_nx   = 4'd0;
            w_blink_nx = 1'b0;
        end else begin
            case (r_state)
                ST_DW: begin
                    if (w_red_rise && (r_req_pend || w_req_pulse)) begin
                        w_state_nx    = ST_WALK;
                        w_cnt_nx      = WALK_CNT;
                        w_req_pend_nx = 1'b0;
                    end else if (w_req_pulse) begin
                        w_req_pend_nx = 1'b1;
                    end
                end
                ST_WALK: begin
                    if (!red) begin
                        w_state_nx = ST_DW;
                        w_cnt_nx   = 4'd0;
                    end else if (tick) begin
                        if (r_cnt == 4'd1) begin
                            w_state_nx = ST_FLASH;
                            w_cnt_nx   = FLASH_CNT;
                            w_blink_nx = 1'b1;
                        end else begin
                            w_cnt_nx = r_cnt - 4'd1;
                        end
                    end
                end
                ST_FLASH: begin
                    if (w_req_pulse) w_req_pend_nx = 1'b1;
                    if (!red) begin
                        w_state_nx = ST_DW;
                        w_cnt_nx   = 4'd0;
                    end else if (tick) begin
                        w_blink_nx = ~r_blink;
                        if (r_cnt == 4'd1) begin
                            w_state_nx = ST_DW;
                            w_cnt_nx   = 4'd0;
                        end else begin
                            w_cnt_nx = r_cnt - 4'd1;
                        end
                    end
                end
                ST_FAULT: begin
                    if (!w_bad && green) w_state_nx = ST_DW;
                end
                default: w_state_nx = ST_DW;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_DW;
            r_cnt       <= 4'd0;
            r_blink     <= 1'b0;
            r_req_pend  <= 1'b0;
            r_red_d     <= 1'b0;
            r_bad_d     <= 1'b0;
            r_walk      <= 1'b0;
            r_dont_walk <= 1'b1;
            r_countdown <= 4'd0;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_blink     <= w_blink_nx;
            r_req_pend  <= w_req_pend_nx;
            r_red_d     <= red;
            r_bad_d     <= w_bad;
            // Lamps are registered from the next state so they change together with it
            r_walk      <= (w_state_nx == ST_WALK);
            r_dont_walk <= (w_state_nx == ST_FLASH) ? w_blink_nx : (w_state_nx != ST_WALK);
            r_countdown <= (w_state_nx == ST_WALK || w_state_nx == ST_FLASH) ? w_cnt_nx : 4'd0;
            r_fault     <= (w_state_nx == ST_FAULT);
        end
    end

    assign walk      = r_walk;
    assign dont_walk = r_dont_walk;
    assign req_pend  = r_req_pend;
    assign countdown = r_countdown;
    assign fault     = r_fault;

endmodule
